// File: rtl/alu_pipelined_ripple.sv
// rtl/alu_pipelined_ripple.sv - WIDTH-bit ripple ALU split into SLICE-bit pipeline stages
// Carry is registered between stages; all stages advance together on adv.
module alu_pipelined_ripple #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal_op
);

  localparam int L = WIDTH / SLICE;
  localparam int M = L - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < L; k++) begin : g_st
    logic [WIDTH-1:0] ia, ib, ir, nr;
    logic [3:0]       iop;
    logic             ic, iv, nc;
    logic [SLICE-1:0] sa, sb, bx, res;
    logic [SLICE:0]   sum;

    if (k == 0) begin : g_in
      assign ia  = a;
      assign ib  = b;
      assign ir  = '0;
      assign iop = alu_op;
      assign iv  = in_valid;
      // SUB and SLT form a + ~b + 1, so the first slice starts with carry 1
      always_comb begin
        case (alu_op)
          OP_ADD:         ic = carry_in;
          OP_SUB, OP_SLT: ic = 1'b1;
          default:        ic = 1'b0;
        endcase
      end
    end else begin : g_prev
      assign ia  = g_st[k-1].g_r.ra;
      assign ib  = g_st[k-1].g_r.rb;
      assign ir  = g_st[k-1].g_r.rr;
      assign iop = g_st[k-1].g_r.rop;
      assign iv  = g_st[k-1].g_r.rv;
      assign ic  = g_st[k-1].g_r.rc;
    end

    assign sa  = ia[k*SLICE +: SLICE];
    assign sb  = ib[k*SLICE +: SLICE];
    assign bx  = (iop == OP_ADD) ? sb : ~sb;
    assign sum = {1'b0, sa} + {1'b0, bx} + {{SLICE{1'b0}}, ic};
    assign nc  = sum[SLICE];

    always_comb begin
      case (iop)
        OP_AND:                 res = sa & sb;
        OP_OR:                  res = sa | sb;
        OP_XOR:                 res = sa ^ sb;
        OP_NOR:                 res = ~(sa | sb);
        OP_ADD, OP_SUB, OP_SLT: res = sum[SLICE-1:0];
        default:                res = '0;
      endcase
      nr = ir;
      nr[k*SLICE +: SLICE] = res;
    end

    if (k < L - 1) begin : g_r
      logic [WIDTH-1:0] ra, rb, rr;
      logic [3:0]       rop;
      logic             rc, rv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rv  <= 1'b0;
          ra  <= '0;
          rb  <= '0;
          rr  <= '0;
          rop <= '0;
          rc  <= 1'b0;
        end else if (adv) begin
          rv  <= iv;
          ra  <= ia;
          rb  <= ib;
          rr  <= nr;
          rop <= iop;
          rc  <= nc;
        end
      end
    end
  end

  // Last slice holds the MSBs, so sign-related flags are resolved here
  logic msb_a, msb_b, msb_s, ovf;
  assign msb_a = g_st[M].sa[SLICE-1];
  assign msb_b = g_st[M].bx[SLICE-1];
  assign msb_s = g_st[M].sum[SLICE-1];
  assign ovf   = (msb_a == msb_b) && (msb_s != msb_a);

  logic [WIDTH-1:0] fin_r;
  logic             fin_c, fin_v, fin_ill;

  always_comb begin
    fin_r   = g_st[M].nr;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_ill = 1'b0;
    case (g_st[M].iop)
      OP_AND, OP_OR, OP_XOR, OP_NOR: begin
      end
      OP_ADD, OP_SUB: begin
        fin_c = g_st[M].nc;
        fin_v = ovf;
      end
      OP_SLT: fin_r = {{(WIDTH-1){1'b0}}, msb_s ^ ovf};
      default: begin
        fin_r   = '0;
        fin_ill = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
      zero       <= 1'b0;
      negative   <= 1'b0;
    end else if (adv) begin
      out_valid  <= g_st[M].iv;
      result     <= fin_r;
      carry_out  <= fin_c;
      overflow   <= fin_v;
      illegal_op <= fin_ill;
      zero       <= (fin_r == '0);
      negative   <= fin_r[WIDTH-1];
    end
  end

  logic unused_lsbs;
  assign unused_lsbs = ^{g_st[M].ia, g_st[M].ib};

endmodule

// File: tb/tb_alu_pipelined_ripple.sv
// tb/tb_alu_pipelined_ripple.sv - self-checking bench for alu_pipelined_ripple
module tb_alu_pipelined_ripple;
  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int L     = 4;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              in_valid = 1'b0, in_ready, carry_in = 1'b0;
  logic [WIDTH-1:0]  a = '0, b = '0, result;
  logic [3:0]        alu_op = '0;
  logic              out_valid, out_ready = 1'b0;
  logic              carry_out, zero, negative, overflow, illegal_op;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] r;
    logic co, ov, z, n, ill;
    int   iss;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_pipelined_ripple #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .zero(zero), .negative(negative),
    .overflow(overflow), .illegal_op(illegal_op)
  );

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci);
    exp_t e;
    logic [32:0] s;
    e.r = '0; e.co = 1'b0; e.ov = 1'b0; e.ill = 1'b0; e.iss = 0;
    case (op)
      4'b0000: e.r = x & y;
      4'b0001: e.r = x | y;
      4'b0011: e.r = x ^ y;
      4'b1100: e.r = ~(x | y);
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        e.r = s[31:0]; e.co = s[32];
        e.ov = (x[31] == y[31]) && (e.r[31] != x[31]);
      end
      4'b0110: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.r = s[31:0]; e.co = s[32];
        e.ov = (x[31] != y[31]) && (e.r[31] != x[31]);
      end
      4'b0111: e.r = {31'd0, ($signed(x) < $signed(y))};
      default: e.ill = 1'b1;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic ci);
    in_valid = 1'b1; alu_op = op; a = x; b = y; carry_in = ci;
  endtask

  task automatic push_if_accepted();
    exp_t e;
    if (in_valid && in_ready) begin
      e = model(alu_op, a, b, carry_in);
      e.iss = cyc;
      sb.push_back(e);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] edges [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    case ($urandom_range(0, 3))
      0: return edges[$urandom_range(0, 3)];
      1: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]  to [11] = '{4'b0010, 4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b0011, 4'b1111,
                             4'b0000, 4'b0001, 4'b1100, 4'b0110};
    logic [31:0] ta [11] = '{32'h000000FF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1,
                             32'hA5A5A5A5, 32'h12345678, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0, 32'h5};
    logic [31:0] tb_[11] = '{32'h1, 32'h0, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFF0000,
                             32'h9ABCDEF0, 32'hFF00FF00, 32'h000000F0, 32'h0, 32'h5};
    logic        tc [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int idx = 0;
    exp_t e;
    for (int c = 0; c < 80 && !(idx == 11 && sb.size() == 0); c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (idx < 11) drive(to[idx], ta[idx], tb_[idx], tc[idx]);
      else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) idx++;
      push_if_accepted();
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL dir_unexpected got result %h with nothing outstanding", result);
        end else begin
          e = sb.pop_front();
          if ({result, carry_out, overflow, zero, negative, illegal_op} !== {e.r, e.co, e.ov, e.z, e.n, e.ill}) begin
            errors++;
            $display("FAIL dir_result got r=%h c=%b v=%b z=%b n=%b ill=%b want r=%h c=%b v=%b z=%b n=%b ill=%b",
                     result, carry_out, overflow, zero, negative, illegal_op, e.r, e.co, e.ov, e.z, e.n, e.ill);
          end
          checks++;
          if (cyc - e.iss !== L) begin
            errors++; $display("FAIL dir_latency got %0d want %0d", cyc - e.iss, L);
          end
        end
      end
    end
    checks++;
    if (idx != 11 || sb.size() != 0) begin
      errors++; $display("FAIL dir_timeout issued %0d outstanding %0d want 11 and 0", idx, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  to [6] = '{4'b0010, 4'b0110, 4'b0011, 4'b0111, 4'b0001, 4'b0000};
    logic [31:0] ta [6] = '{32'h11111111, 32'h00000010, 32'hDEADBEEF, 32'h80000000, 32'h00F000F0, 32'hCAFEF00D};
    logic [31:0] tb_[6] = '{32'h22222222, 32'h00000020, 32'h0F0F0F0F, 32'h7FFFFFFF, 32'h0F000F00, 32'h0000FFFF};
    int issued = 0, popped = 0, stall_left = 5, last_pop = 0;
    bit seen = 0;
    logic [31:0] held = '0;
    exp_t e;
    for (int c = 0; c < 80 && popped < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      if (seen && stall_left > 0) begin
        if (stall_left == 5) held = result;
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (issued < 6) drive(to[issued], ta[issued], tb_[issued], 1'b0);
      else in_valid = 1'b0;
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
        checks++;
        if (result !== held || out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_hold got r=%h v=%b want r=%h v=1", result, out_valid, held);
        end
      end
      if (in_valid && in_ready) issued++;
      push_if_accepted();
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got result %h with nothing outstanding", result);
        end else begin
          e = sb.pop_front();
          if ({result, carry_out, overflow, zero, negative, illegal_op} !== {e.r, e.co, e.ov, e.z, e.n, e.ill}) begin
            errors++;
            $display("FAIL b2b_result got r=%h c=%b v=%b z=%b n=%b ill=%b want r=%h c=%b v=%b z=%b n=%b ill=%b",
                     result, carry_out, overflow, zero, negative, illegal_op, e.r, e.co, e.ov, e.z, e.n, e.ill);
          end
        end
        if (popped > 0) begin
          checks++;
          if (cyc - last_pop !== 1) begin
            errors++; $display("FAIL b2b_spacing got %0d cycles want 1", cyc - last_pop);
          end
        end
        last_pop = cyc;
        popped++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (popped != 6 || sb.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d results %0d outstanding want 6 and 0", popped, sb.size());
    end
  endtask

  task automatic test_reset_flight();
    exp_t e;
    bit got = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(4'b0010, 32'(i + 100), 32'(i), 1'b0);
      #1;
      push_if_accepted();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got out_valid %b want 0 (cycle %0d)", out_valid, i); end
    end
    @(negedge clk);
    drive(4'b0010, 32'd2, 32'd3, 1'b0);
    #1;
    push_if_accepted();
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        got = 1;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rst_add_unexpected got result %h with nothing outstanding", result);
        end else begin
          e = sb.pop_front();
          if (result !== 32'd5 || result !== e.r || carry_out !== e.co || zero !== e.z) begin
            errors++; $display("FAIL rst_add got r=%h c=%b z=%b want r=%h c=%b z=%b", result, carry_out, zero, e.r, e.co, e.z);
          end
          checks++;
          if (cyc - e.iss !== L) begin errors++; $display("FAIL rst_add_latency got %0d want %0d", cyc - e.iss, L); end
        end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rst_add_timeout got no result want 1"); end
  endtask

  task automatic test_random();
    logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1100, 4'b1111};
    int issued = 0;
    bit pend = 0;
    exp_t e;
    for (int c = 0; c < 20000 && !(issued >= 1000 && sb.size() == 0); c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      if (!pend && issued < 1000 && $urandom_range(0, 9) < 7) begin
        drive(($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 7)],
              rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        pend = 1;
      end
      in_valid = pend;
      #1;
      if (in_valid && in_ready) begin pend = 0; issued++; end
      push_if_accepted();
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected got result %h with nothing outstanding", result);
        end else begin
          e = sb.pop_front();
          if ({result, carry_out, overflow, zero, negative, illegal_op} !== {e.r, e.co, e.ov, e.z, e.n, e.ill}) begin
            errors++;
            $display("FAIL rnd_result got r=%h c=%b v=%b z=%b n=%b ill=%b want r=%h c=%b v=%b z=%b n=%b ill=%b",
                     result, carry_out, overflow, zero, negative, illegal_op, e.r, e.co, e.ov, e.z, e.n, e.ill);
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (issued != 1000 || sb.size() != 0) begin
      errors++; $display("FAIL rnd_timeout issued %0d outstanding %0d want 1000 and 0", issued, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipelined_ripple.md
Name: alu_pipelined_ripple

Overview:
- Parametrised successor of the team's fixed 8-bit ripple ALU.
- Splits a WIDTH-bit ripple-carry ALU into SLICE-bit segments, one segment per pipeline stage.
- The carry registers between stages, so the clock period is set by one SLICE-bit ripple rather than the full width.
- Adds a valid/ready handshake on both sides, a stall path and status flags. It sits in the EX stage of the pipelined processor.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, bits computed per stage; must be at least 1.
- L (localparam), WIDTH/SLICE, number of pipeline stages and the latency in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0; used by ADD only.
- alu_op  in  4  operation code.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result.
- carry_out  out  1  carry out of the MSB.
- zero  out  1  result equals 0.
- negative  out  1  result[WIDTH-1].
- overflow  out  1  signed overflow.
- illegal_op  out  1  alu_op was not a defined code.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0011 XOR; 1100 NOR.
  - 0010 ADD: a+b+carry_in.
  - 0110 SUB: a+~b+1; carry_in ignored.
  - 0111 SLT: signed a<b; result is {0…0, lt}.
  - Any other code: result 0, carry_out 0, overflow 0, illegal_op 1.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, driven combinationally; there is no combinational path from in_valid.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- Stage k (0..L-1) computes bits [k*SLICE +: SLICE] using the carry registered by stage k-1; stage 0 uses the op-dependent carry-in.
- Skew registers carry the unprocessed operand slices, the partial result, the op and a valid bit forward one stage per adv edge.
- Latency: out_valid rises exactly L edges after the accepting edge when adv stays 1. Throughput is one op per cycle.
- Stall: when out_valid && !out_ready, every stage, including the output register, holds. result and the flags stay stable and no op is dropped or duplicated.
- Bubbles: empty stages advance normally when adv=1; they are never compressed while stalled.
- Flags are registered with the result, at the last stage:
  - carry_out: MSB carry for ADD/SUB; 0 for all other ops. For SUB, 1 means no borrow.
  - overflow: for ADD/SUB, set when the operand MSBs (b inverted for SUB) are equal and the result MSB differs from them; 0 otherwise.
  - SLT: lt = N xor V of a-b. carry_out and overflow report 0.
  - zero = (result == 0); negative = result[WIDTH-1]. Both apply to all ops, including illegal ones.
- Degenerate case: L=1 is a single-stage registered ALU with identical handshake.
- Reset:
  - All valid bits, result, flags and illegal_op go to 0 asynchronously; in_ready reads 1.
  - Reset mid-operation discards in-flight ops; nothing emerges after release.
  - Release is synchronised by the integrating level.
- Outputs when out_valid=0 are don't-care; the bench must not check them.

Test Plan (WIDTH=32, SLICE=8, L=4):
- ADD a=0x000000FF, b=0x00000001, cin=0, out_ready=1 -> result 0x00000100, carry_out 0, zero 0; out_valid exactly 4 cycles after accept. This checks the inter-stage carry.
- ADD a=0xFFFFFFFF, b=0, cin=1 -> result 0, carry_out 1, zero 1, overflow 0. SUB a=0x80000000, b=1 -> 0x7FFFFFFF, overflow 1, carry_out 1.
- SLT a=0xFFFFFFFF, b=1 -> result 1, negative 0. SLT a=1, b=0xFFFFFFFF -> 0, zero 1. XOR 0xA5A5A5A5^0xFFFF0000 -> 0x5A5AA5A5. alu_op=1111 -> result 0, illegal_op 1.
- Issue 6 back-to-back ops and hold out_ready=0 once the first result appears:
  - in_ready drops the same cycle; result is held stable.
  - On release, the 6 results emerge in issue order, one per cycle, with no loss.
- Assert rst_n=0 with 3 ops in flight -> out_valid 0 immediately and in_ready 1. No stale result appears in the 8 cycles after release; a new ADD 2+3 -> 5 arrives 4 cycles after accept.
- Randomised run of 1000 ops with random in_valid/out_ready against a reference model of the opcode set -> all results and flags match, in order.
